axis_pkt_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI4-Stream output among NUM_PORTS input streams. A grant is taken at packet start and held until the granted source's tlast beat is accepted, so packets are never interleaved. It sits upstream of the shared egress path (for example, ahead of a skid buffer or MAC transmit stage) and tags each beat with its source port.

---
 rtl/axis_pkt_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI4-Stream output among NUM_PORTS
// sources, holding each grant from the first beat until the tlast beat is accepted.
module axis_pkt_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic                            grant_valid,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            pkt_done
);

  localparam int unsigned CW = ID_WIDTH + 1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t              state, state_d;
  logic [ID_WIDTH-1:0] grant_d;
  logic [ID_WIDTH-1:0] rr_ptr, rr_d;
  logic                pkt_done_d;
  logic [ID_WIDTH-1:0] pick;
  logic                pick_found;
  logic [CW-1:0]       scan_idx;

  // Rotating-priority scan starting at rr_ptr, wrapping modulo NUM_PORTS
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_idx = CW'(rr_ptr) + CW'(k);
      if (scan_idx >= CW'(NUM_PORTS)) begin
        scan_idx = scan_idx - CW'(NUM_PORTS);
      end
      if (!pick_found && s_axis_tvalid[ID_WIDTH'(scan_idx)]) begin
        pick_found = 1'b1;
        pick       = ID_WIDTH'(scan_idx);
      end
    end
  end

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_d;
      grant_id <= grant_d;
      rr_ptr   <= rr_d;
      pkt_done <= pkt_done_d;
    end
  end

  // Next-state logic and the combinational datapath from the granted port
  always_comb begin
    state_d       = state;
    grant_d       = grant_id;
    rr_d          = rr_ptr;
    pkt_done_d    = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tid    = '0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        m_axis_tvalid           = s_axis_tvalid[grant_id];
        m_axis_tlast            = s_axis_tlast[grant_id];
        m_axis_tdata            = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tid              = grant_id;
        s_axis_tready[grant_id] = m_axis_tready;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d    = S_IDLE;
          pkt_done_d = 1'b1;
          rr_d       = (grant_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_id + ID_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_valid = (state == S_LOCKED);

endmodule
